// File: rtl/vga_capture_if.sv
// Sync/pixel stream into the capture block and the recovered
// pixel, timing-error and lock results out of it.
interface vga_capture_if;
  logic       hs;
  logic       vs;
  logic       rdyn;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [11:0] pix_color;
  logic       pix_valid;
  logic       frame_start;
  logic       locked;
  logic       err_hline;
  logic       err_vframe;
  logic [9:0] meas_h_total;
  logic [9:0] meas_v_total;

  modport master (
    output hs, vs, rdyn, r, g, b,
    input  pix_x, pix_y, pix_color, pix_valid,
    input  frame_start, locked, err_hline, err_vframe,
    input  meas_h_total, meas_v_total
  );

  modport slave (
    input  hs, vs, rdyn, r, g, b,
    output pix_x, pix_y, pix_color, pix_valid,
    output frame_start, locked, err_hline, err_vframe,
    output meas_h_total, meas_v_total
  );
endinterface

// File: rtl/vga_capture.sv
// VGA receive-side monitor: recovers pixel coordinates, measures
// line/frame timing against the expected mode and tracks lock.
module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic         clk,
  input  logic         rst,
  vga_capture_if.slave bus
);
  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_e;

  localparam logic [9:0] SAT = 10'd1023;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == SAT) ? v : v + 10'd1;
  endfunction

  logic       hs_q, vs_q, rdyn_q;
  logic       hs_p_q, vs_p_q;
  logic [3:0] r_q, g_q, b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      hs_p_q <= 1'b0;
      vs_p_q <= 1'b0;
      rdyn_q <= 1'b1;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      hs_q   <= bus.hs;
      vs_q   <= bus.vs;
      hs_p_q <= hs_q;
      vs_p_q <= vs_q;
      rdyn_q <= bus.rdyn;
      r_q    <= bus.r;
      g_q    <= bus.g;
      b_q    <= bus.b;
    end
  end

  state_e     state_q, state_d;
  logic [2:0] good_q, good_d;
  logic       seen_q, seen_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] a_cnt_q, a_cnt_d;
  logic [9:0] l_cnt_q, l_cnt_d;
  logic [9:0] al_cnt_q, al_cnt_d;

  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic [11:0] pix_c_q, pix_c_d;
  logic        pix_v_q, pix_v_d;
  logic        fs_q, fs_d;
  logic        eh_q, eh_d;
  logic        ev_q, ev_d;
  logic [9:0]  mh_q, mh_d;
  logic [9:0]  mv_q, mv_d;

  logic       hs_rise, vs_rise, hunt, los;
  logic [9:0] h_len, l_post, al_post;
  logic       line_bad, frame_bad, eh, ev;

  assign hs_rise = hs_q & ~hs_p_q;
  assign vs_rise = vs_q & ~vs_p_q;
  assign hunt    = (state_q == HUNT);
  assign h_len   = sat_inc(h_cnt_q);
  assign los     = ~hs_rise & (h_cnt_q == SAT);
  assign l_post  = hs_rise ? sat_inc(l_cnt_q) : l_cnt_q;
  assign al_post = (hs_rise && a_cnt_q != '0)
                 ? sat_inc(al_cnt_q) : al_cnt_q;

  assign line_bad  = (h_len != 10'(H_TOTAL))
                   | ((a_cnt_q != '0)
                   & (a_cnt_q != 10'(H_ACTIVE)));
  assign frame_bad = (l_post != 10'(V_TOTAL))
                   | (al_post != 10'(V_ACTIVE));

  assign eh = hs_rise & ~hunt & line_bad;
  assign ev = vs_rise & ~hunt & frame_bad & ~los;

  always_comb begin
    h_cnt_d  = hs_rise ? '0 : h_len;
    a_cnt_d  = a_cnt_q;
    if (hs_rise)
      a_cnt_d = '0;
    else if (!rdyn_q)
      a_cnt_d = sat_inc(a_cnt_q);
    l_cnt_d  = vs_rise ? '0 : l_post;
    al_cnt_d = vs_rise ? '0 : al_post;

    state_d = state_q;
    good_d  = good_q;
    seen_d  = vs_rise ? 1'b0 : (seen_q | eh);

    unique case (state_q)
      HUNT: begin
        if (vs_rise) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (vs_rise) begin
          if (seen_q | eh | ev) begin
            good_d = '0;
          end else begin
            good_d = good_q + 3'd1;
            if (good_d == 3'(LOCK_FRAMES))
              state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (eh | ev) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      default: state_d = HUNT;
    endcase

    // h_cnt stuck at saturation means the sync stream has gone away
    if (los) begin
      state_d  = HUNT;
      good_d   = '0;
      seen_d   = 1'b0;
      h_cnt_d  = '0;
      a_cnt_d  = '0;
      l_cnt_d  = '0;
      al_cnt_d = '0;
    end
  end

  always_comb begin
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    pix_c_d = pix_c_q;
    if (!rdyn_q) begin
      pix_x_d = a_cnt_q;
      pix_y_d = al_cnt_q;
      pix_c_d = {b_q, g_q, r_q};
    end
    pix_v_d = ~rdyn_q & ~hunt & ~los
            & (a_cnt_q < 10'(H_ACTIVE));
    fs_d    = vs_rise;
    eh_d    = eh;
    ev_d    = ev;
    mh_d    = hs_rise ? h_len : mh_q;
    mv_d    = vs_rise ? l_post : mv_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      good_q   <= '0;
      seen_q   <= 1'b0;
      h_cnt_q  <= '0;
      a_cnt_q  <= '0;
      l_cnt_q  <= '0;
      al_cnt_q <= '0;
      pix_x_q  <= '0;
      pix_y_q  <= '0;
      pix_c_q  <= '0;
      pix_v_q  <= 1'b0;
      fs_q     <= 1'b0;
      eh_q     <= 1'b0;
      ev_q     <= 1'b0;
      mh_q     <= '0;
      mv_q     <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      seen_q   <= seen_d;
      h_cnt_q  <= h_cnt_d;
      a_cnt_q  <= a_cnt_d;
      l_cnt_q  <= l_cnt_d;
      al_cnt_q <= al_cnt_d;
      pix_x_q  <= pix_x_d;
      pix_y_q  <= pix_y_d;
      pix_c_q  <= pix_c_d;
      pix_v_q  <= pix_v_d;
      fs_q     <= fs_d;
      eh_q     <= eh_d;
      ev_q     <= ev_d;
      mh_q     <= mh_d;
      mv_q     <= mv_d;
    end
  end

  assign bus.pix_x        = pix_x_q;
  assign bus.pix_y        = pix_y_q;
  assign bus.pix_color    = pix_c_q;
  assign bus.pix_valid    = pix_v_q;
  assign bus.frame_start  = fs_q;
  assign bus.locked       = (state_q == LOCKED);
  assign bus.err_hline    = eh_q;
  assign bus.err_vframe   = ev_q;
  assign bus.meas_h_total = mh_q;
  assign bus.meas_v_total = mv_q;
endmodule
